// File: rtl/fetch_pc_stage_pkg.sv
// Shared pipeline definitions for the RV32I fetch stage.
// Contents: datapath widths, reset/bubble defaults, and a word-alignment
// helper used when a redirect target is loaded into the PC.
package fetch_pc_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Force a fetch address onto a 4-byte boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // True when an address is not on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_pc_stage_incr.sv
// Sequential-PC incrementer: pc_plus4_o = pc_i + 4, wrapping mod 2^32.
// Ports:
//   pc_i       - current fetch address
//   pc_plus4_o - address of the next sequential word
module fetch_pc_stage_incr
    import fetch_pc_stage_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_plus4_o
);

    assign pc_plus4_o = pc_i + 32'd4;

endmodule

// File: rtl/fetch_pc_stage.sv
// Fetch-stage PC register plus IF/ID pipeline register.
// Selects the next PCF from reset, EX redirect (immediate or pending while
// imem is busy), stall/hold, or sequential PC+4, and loads decode with the
// fetched instruction or a bubble.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   StallF, StallD    - hazard-unit holds for PC and IF/ID
//   FlushD            - hazard-unit bubble request for IF/ID
//   PCSrcE, PCTargetE - EX-stage redirect request and target
//   imem_ready, InstrF- imem handshake and instruction for PCF
//   PCF, PCPlus4F     - fetch address and its sequential successor
//   InstrD, PCD, PCPlus4D, ValidD - decode-side pipeline register
//   TargetMisalignF   - one-cycle pulse on an accepted misaligned redirect
module fetch_pc_stage
    import fetch_pc_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            imem_ready,
    input  logic [ILEN-1:0] InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    output logic [ILEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic            TargetMisalignF
);

    logic [XLEN-1:0] pcf_q,         pcf_d;
    logic            pend_valid_q,  pend_valid_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    logic            misalign_q,    misalign_d;
    logic [ILEN-1:0] instr_d_q,     instr_d_d;
    logic [XLEN-1:0] pc_d_q,        pc_d_d;
    logic [XLEN-1:0] pcp4_d_q,      pcp4_d_d;
    logic            valid_d_q,     valid_d_d;

    logic [XLEN-1:0] pcplus4_s;
    logic            redirect_req_s;
    logic            redirect_acc_s;
    logic [XLEN-1:0] redirect_tgt_s;

    fetch_pc_stage_incr u_incr (
        .pc_i       (pcf_q),
        .pc_plus4_o (pcplus4_s)
    );

    // A fresh PCSrcE always supersedes an older pending target.
    assign redirect_req_s = PCSrcE | pend_valid_q;
    assign redirect_acc_s = redirect_req_s & imem_ready;
    assign redirect_tgt_s = PCSrcE ? PCTargetE : pend_target_q;

    // Next-state for PC, pending redirect and misalignment pulse.
    always_comb begin
        pcf_d         = pcf_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        misalign_d    = 1'b0;
        if (redirect_acc_s) begin
            // Redirect wins over StallF: the wrong path must not linger.
            pcf_d        = word_align(redirect_tgt_s);
            pend_valid_d = 1'b0;
            misalign_d   = is_misaligned(redirect_tgt_s);
        end else if (redirect_req_s) begin
            // imem busy: remember the target and retry once ready.
            if (PCSrcE) begin
                pend_target_d = PCTargetE;
                pend_valid_d  = 1'b1;
            end else begin
                pend_target_d = pend_target_q;
                pend_valid_d  = pend_valid_q;
            end
        end else if (StallF || !imem_ready) begin
            pcf_d = pcf_q;
        end else begin
            pcf_d = pcplus4_s;
        end
    end

    // Next-state for the IF/ID pipeline register.
    always_comb begin
        instr_d_d = instr_d_q;
        pc_d_d    = pc_d_q;
        pcp4_d_d  = pcp4_d_q;
        valid_d_d = valid_d_q;
        if (FlushD || redirect_acc_s) begin
            // InstrF belongs to the squashed path; PC fields keep old values.
            instr_d_d = NOP_INSTR;
            valid_d_d = 1'b0;
        end else if (StallD) begin
            valid_d_d = valid_d_q;
        end else if (!imem_ready) begin
            instr_d_d = NOP_INSTR;
            valid_d_d = 1'b0;
        end else begin
            instr_d_d = InstrF;
            pc_d_d    = pcf_q;
            pcp4_d_d  = pcplus4_s;
            valid_d_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcf_q         <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0000_0000;
            misalign_q    <= 1'b0;
            instr_d_q     <= NOP_INSTR;
            pc_d_q        <= 32'h0000_0000;
            pcp4_d_q      <= 32'h0000_0000;
            valid_d_q     <= 1'b0;
        end else begin
            pcf_q         <= pcf_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            misalign_q    <= misalign_d;
            instr_d_q     <= instr_d_d;
            pc_d_q        <= pc_d_d;
            pcp4_d_q      <= pcp4_d_d;
            valid_d_q     <= valid_d_d;
        end
    end

    assign PCF             = pcf_q;
    assign PCPlus4F        = pcplus4_s;
    assign InstrD          = instr_d_q;
    assign PCD             = pc_d_q;
    assign PCPlus4D        = pcp4_d_q;
    assign ValidD          = valid_d_q;
    assign TargetMisalignF = misalign_q;

endmodule
